meta_data_joiner: RTL and testbench
===================================

Name: meta_data_joiner

Overview:
Recombines two copies of a metadata stream, MD1 and MD2, into one AXI-Stream output. This is the receiving end for a broadcast into two parallel consumers. Each input is buffered in its own small FIFO to absorb skew between the paths. A beat is emitted only when both paths have a beat, so the two copies are re-aligned beat-for-beat. The two copies are compared, and divergence is flagged and counted.

Parameters:
DW, 512, data width in bits; multiple of 8.
FIFO_DEPTH, 4, entries per input FIFO; power of 2, >= 2; maximum tolerated skew between the inputs, in beats.
CNT_W, 16, width of the mismatch counter.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
AXIS_IN_MD1_TDATA  input  DW  path-1 metadata
AXIS_IN_MD1_TVALID  input  1  path-1 valid
AXIS_IN_MD1_TREADY  output  1  path-1 ready
AXIS_IN_MD2_TDATA  input  DW  path-2 metadata
AXIS_IN_MD2_TVALID  input  1  path-2 valid
AXIS_IN_MD2_TREADY  output  1  path-2 ready
AXIS_OUT_MD_TDATA  output  DW  joined metadata (path-1 copy)
AXIS_OUT_MD_TVALID  output  1  output valid
AXIS_OUT_MD_TKEEP  output  DW/8  constant all ones
AXIS_OUT_MD_TLAST  output  1  constant 1; each beat is a complete record
AXIS_OUT_MD_TREADY  input  1  downstream ready
MISMATCH  output  1  one-cycle pulse when a joined pair differed
MISMATCH_COUNT  output  CNT_W  saturating count of mismatched pairs

Behaviour:
- Reset (synchronous, while reset=1 at the edge):
  - FIFO pointers and occupancy cleared.
  - AXIS_OUT_MD_TVALID=0, AXIS_OUT_MD_TDATA=0, MISMATCH=0, MISMATCH_COUNT=0.
  - Both TREADY outputs go to 1 in the first cycle after reset deasserts.
  - Reset mid-stream silently discards all buffered beats and any held output beat.
- Input side (per path):
  - TREADY = (occupancy != FIFO_DEPTH). It is derived from registered state only; there is no combinational path from any input.
  - Push on TVALID && TREADY.
  - A full FIFO keeps TREADY=0 even in a cycle where it pops.
  - Push and pop in the same cycle leave occupancy unchanged.
- Join condition: pop = both FIFOs non-empty && (!AXIS_OUT_MD_TVALID || AXIS_OUT_MD_TREADY). When pop is true, both heads pop in the same cycle.
- Output register (on pop):
  - TDATA <= head1 and TVALID <= 1.
  - MISMATCH <= (head1 != head2).
  - If the pair differs and MISMATCH_COUNT < 2^CNT_W-1, the counter increments; it saturates, never wraps.
- Output hold and drain:
  - With TVALID=1 and TREADY=0, TDATA stays stable.
  - With TVALID=1, TREADY=1 and no pop, TVALID <= 0.
- MISMATCH is 0 in every cycle not immediately following a pop.
- Latency: both inputs accepted at edge e into empty FIFOs gives output TVALID=1 after edge e+1. That is 2 cycles input-to-output, and it is the minimum.
- Throughput: one beat per cycle sustained when both inputs stream and downstream is always ready.
- Skew: one path may run up to FIFO_DEPTH beats ahead of the other, after which its TREADY drops until the lagging path catches up. Order is strictly FIFO per path, and pairing is positional (the n-th beat of MD1 joins the n-th beat of MD2).
- Empty path: no output is produced regardless of how full the other path is.

Decomposition:
- Sub-module md_sync_fifo (parameters DW, DEPTH): synchronous FIFO with push/pop, head data, full, empty. Instantiated twice.
- Shared header: clog2 function for pointer widths, plus the constant for the all-ones TKEEP width expression.
- Joiner logic, output register and counter live in the top module.

Test Plan:
1. Both paths send 0xA1, 0xA2, 0xA3 in lockstep, downstream ready=1 -> output 0xA1, 0xA2, 0xA3 on consecutive cycles; first TVALID 2 cycles after first accept; MISMATCH never 1; count stays 0.
2. MD1 sends 6 beats while MD2 valid=0 (FIFO_DEPTH=4) -> MD1 TREADY drops after 4 accepts and no output appears. MD2 then sends 4 beats -> 4 outputs in MD1 order and MD1 TREADY returns to 1.
3. Pair MD1=0x55, MD2=0x54 -> output TDATA 0x55; MISMATCH pulses for exactly 1 cycle with that beat; count becomes 1. Next equal pair -> MISMATCH=0 and count stays 1.
4. Downstream TREADY=0 for 5 cycles with output valid holding 0x10 -> TDATA stays 0x10 throughout. FIFOs fill to 4 and both TREADY=0. On release, beats drain one per cycle with no loss or duplication.
5. CNT_W=2, 5 mismatched pairs -> count reads 1, 2, 3, 3, 3 (saturates).
6. Assert reset while 3 beats are buffered and TVALID=1 -> next cycle TVALID=0, count=0, both TREADY=1. The next lockstep pair 0x77 emerges as the first output.

Source files
------------

// File: rtl/meta_data_joiner_pkg.sv
// Shared helpers for the metadata joiner slice.
//   clog2  : pointer width for a FIFO of a given depth
//   keep_w : byte-enable (TKEEP) width for a given data width
package meta_data_joiner_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int keep_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/meta_data_joiner_if.sv
// AXI-Stream style bus used by the joiner.
//   master : drives tdata/tvalid/tkeep/tlast, samples tready
//   slave  : samples tdata/tvalid, drives tready (inputs carry no keep/last)
interface meta_data_joiner_if import meta_data_joiner_pkg::*; #(
  parameter int DW = 512
);
  logic [DW-1:0]         tdata;
  logic                  tvalid;
  logic                  tready;
  logic [keep_w(DW)-1:0] tkeep;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tkeep, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/meta_data_joiner_md_sync_fifo.sv
// Synchronous FIFO buffering one metadata path.
//   clk, reset  : clock, synchronous active-high reset
//   push/data   : write request (ignored while full, even if popping)
//   pop         : read request (ignored while empty)
//   head        : oldest entry
//   full, empty : registered occupancy flags
module md_sync_fifo import meta_data_joiner_pkg::*; #(
  parameter int DW    = 512,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          do_push, do_pop;

  // full gates push even on a pop cycle so tready stays purely registered
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/meta_data_joiner.sv
// Rejoins two copies of a metadata stream beat-for-beat.
//   clk, reset     : clock, synchronous active-high reset
//   axis_in_md1    : path-1 metadata (slave)
//   axis_in_md2    : path-2 metadata (slave)
//   axis_out_md    : joined stream, path-1 copy, keep all-ones, last=1 (master)
//   mismatch       : one-cycle pulse alongside a beat whose copies differed
//   mismatch_count : saturating count of differing pairs
module meta_data_joiner import meta_data_joiner_pkg::*; #(
  parameter int DW         = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  meta_data_joiner_if.slave   axis_in_md1,
  meta_data_joiner_if.slave   axis_in_md2,
  meta_data_joiner_if.master  axis_out_md,
  output logic                mismatch,
  output logic [CNT_W-1:0]    mismatch_count
);
  logic [DW-1:0] head1, head2, out_data;
  logic          full1, full2, empty1, empty2;
  logic          out_valid, pop, differ;

  // pop only when both paths hold a beat and the output slot is free/draining
  assign pop    = !empty1 && !empty2 && (!out_valid || axis_out_md.tready);
  assign differ = (head1 != head2);

  md_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset),
    .push(axis_in_md1.tvalid), .push_data(axis_in_md1.tdata),
    .pop(pop), .head(head1), .full(full1), .empty(empty1)
  );

  md_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .reset(reset),
    .push(axis_in_md2.tvalid), .push_data(axis_in_md2.tdata),
    .pop(pop), .head(head2), .full(full2), .empty(empty2)
  );

  assign axis_in_md1.tready = !full1;
  assign axis_in_md2.tready = !full2;

  assign axis_out_md.tdata  = out_data;
  assign axis_out_md.tvalid = out_valid;
  assign axis_out_md.tkeep  = '1;
  assign axis_out_md.tlast  = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data       <= '0;
      out_valid      <= 1'b0;
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else begin
      mismatch <= 1'b0;
      if (pop) begin
        out_data  <= head1;
        out_valid <= 1'b1;
        mismatch  <= differ;
        if (differ && (mismatch_count != '1))
          mismatch_count <= mismatch_count + 1'b1;
      end else if (axis_out_md.tready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_meta_data_joiner.sv
module tb_meta_data_joiner;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mismatch;
  logic [1:0] cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  meta_data_joiner_if #(.DW(DW)) md1 ();
  meta_data_joiner_if #(.DW(DW)) md2 ();
  meta_data_joiner_if #(.DW(DW)) mo ();

  meta_data_joiner #(.DW(DW), .FIFO_DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .axis_in_md1(md1), .axis_in_md2(md2), .axis_out_md(mo),
    .mismatch(mismatch), .mismatch_count(cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    md1.tvalid = 0; md1.tdata = '0; md1.tkeep = '1; md1.tlast = 1'b1;
    md2.tvalid = 0; md2.tdata = '0; md2.tkeep = '1; md2.tlast = 1'b1;
    mo.tready = 1;

    // reset state
    step(); step();
    reset = 0;
    step();
    chk("rst_tvalid", 64'(mo.tvalid), 0);
    chk("rst_tdata", 64'(mo.tdata), 0);
    chk("rst_mismatch", 64'(mismatch), 0);
    chk("rst_count", 64'(cnt), 0);
    chk("rst_tready1", 64'(md1.tready), 1);
    chk("rst_tready2", 64'(md2.tready), 1);
    chk("rst_tkeep", 64'(mo.tkeep), 64'hF);
    chk("rst_tlast", 64'(mo.tlast), 1);

    // 1: lockstep, 2-cycle latency
    md1.tvalid = 1; md2.tvalid = 1;
    md1.tdata = 32'hA1; md2.tdata = 32'hA1; step();
    chk("t1_lat_tvalid", 64'(mo.tvalid), 0);
    md1.tdata = 32'hA2; md2.tdata = 32'hA2; step();
    chk("t1_b0_tvalid", 64'(mo.tvalid), 1);
    chk("t1_b0", 64'(mo.tdata), 64'hA1);
    md1.tdata = 32'hA3; md2.tdata = 32'hA3; step();
    chk("t1_b1", 64'(mo.tdata), 64'hA2);
    chk("t1_mm", 64'(mismatch), 0);
    md1.tvalid = 0; md2.tvalid = 0; step();
    chk("t1_b2", 64'(mo.tdata), 64'hA3);
    chk("t1_b2_tvalid", 64'(mo.tvalid), 1);
    step();
    chk("t1_drain", 64'(mo.tvalid), 0);
    chk("t1_count", 64'(cnt), 0);

    // 2: MD1 runs ahead, MD2 silent
    md1.tvalid = 1;
    for (int i = 0; i < 4; i++) begin
      md1.tdata = 32'hB0 + 32'(i);
      step();
    end
    chk("t2_full_tready1", 64'(md1.tready), 0);
    chk("t2_no_out", 64'(mo.tvalid), 0);
    md1.tdata = 32'hB4; step(); step();
    chk("t2_still_full", 64'(md1.tready), 0);
    chk("t2_still_no_out", 64'(mo.tvalid), 0);
    md1.tvalid = 0;
    md2.tvalid = 1; md2.tdata = 32'hB0; step();
    chk("t2_m2_first", 64'(mo.tvalid), 0);
    chk("t2_m2_tready1", 64'(md1.tready), 0);
    md2.tdata = 32'hB1; step();
    chk("t2_o0", 64'(mo.tdata), 64'hB0);
    chk("t2_tready1_back", 64'(md1.tready), 1);
    md2.tdata = 32'hB2; step();
    chk("t2_o1", 64'(mo.tdata), 64'hB1);
    md2.tdata = 32'hB3; step();
    chk("t2_o2", 64'(mo.tdata), 64'hB2);
    md2.tvalid = 0; step();
    chk("t2_o3", 64'(mo.tdata), 64'hB3);
    chk("t2_o3_tvalid", 64'(mo.tvalid), 1);
    step();
    chk("t2_drain", 64'(mo.tvalid), 0);
    chk("t2_count", 64'(cnt), 0);

    // 3: mismatch pulse
    md1.tvalid = 1; md2.tvalid = 1;
    md1.tdata = 32'h55; md2.tdata = 32'h54; step();
    chk("t3_mm_pre", 64'(mismatch), 0);
    md1.tdata = 32'h66; md2.tdata = 32'h66; step();
    chk("t3_data", 64'(mo.tdata), 64'h55);
    chk("t3_mm", 64'(mismatch), 1);
    chk("t3_count1", 64'(cnt), 1);
    md1.tvalid = 0; md2.tvalid = 0; step();
    chk("t3_eq_data", 64'(mo.tdata), 64'h66);
    chk("t3_eq_mm", 64'(mismatch), 0);
    chk("t3_eq_count", 64'(cnt), 1);
    step();
    chk("t3_idle_mm", 64'(mismatch), 0);
    chk("t3_idle_tvalid", 64'(mo.tvalid), 0);

    // 4: downstream stall, hold and backpressure
    mo.tready = 0;
    md1.tvalid = 1; md2.tvalid = 1;
    md1.tdata = 32'h10; md2.tdata = 32'h10; step();
    md1.tdata = 32'h11; md2.tdata = 32'h11; step();
    chk("t4_hold_first", 64'(mo.tdata), 64'h10);
    for (int i = 0; i < 5; i++) begin
      md1.tdata = 32'h12 + 32'(i); md2.tdata = 32'h12 + 32'(i);
      step();
      chk("t4_hold_data", 64'(mo.tdata), 64'h10);
      chk("t4_hold_tvalid", 64'(mo.tvalid), 1);
    end
    chk("t4_full_tready1", 64'(md1.tready), 0);
    chk("t4_full_tready2", 64'(md2.tready), 0);
    md1.tvalid = 0; md2.tvalid = 0; mo.tready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_drain_data", 64'(mo.tdata), 64'h11 + 64'(i));
      chk("t4_drain_tvalid", 64'(mo.tvalid), 1);
    end
    chk("t4_tready1_back", 64'(md1.tready), 1);
    step();
    chk("t4_no_dup", 64'(mo.tvalid), 0);

    // 6: reset mid-stream
    mo.tready = 0;
    md1.tvalid = 1; md2.tvalid = 1;
    for (int i = 0; i < 4; i++) begin
      md1.tdata = 32'h20 + 32'(i); md2.tdata = 32'h21 + 32'(i);
      step();
    end
    chk("t6_pre_tvalid", 64'(mo.tvalid), 1);
    md1.tvalid = 0; md2.tvalid = 0;
    reset = 1; step();
    reset = 0;
    chk("t6_tvalid", 64'(mo.tvalid), 0);
    chk("t6_count", 64'(cnt), 0);
    chk("t6_tready1", 64'(md1.tready), 1);
    chk("t6_tready2", 64'(md2.tready), 1);
    mo.tready = 1;
    md1.tvalid = 1; md2.tvalid = 1;
    md1.tdata = 32'h77; md2.tdata = 32'h77; step();
    md1.tvalid = 0; md2.tvalid = 0; step();
    chk("t6_first_tvalid", 64'(mo.tvalid), 1);
    chk("t6_first_data", 64'(mo.tdata), 64'h77);
    step();
    chk("t6_only_one", 64'(mo.tvalid), 0);

    // 5: saturating counter, CNT_W=2
    for (int i = 0; i < 5; i++) begin
      md1.tvalid = 1; md2.tvalid = 1;
      md1.tdata = 32'h30 + 32'(i); md2.tdata = 32'h40 + 32'(i);
      step();
      md1.tvalid = 0; md2.tvalid = 0;
      step();
      chk("t5_mm", 64'(mismatch), 1);
      chk("t5_count", 64'(cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
